// File: rtl/cpu_mem_pkg.sv
// Shared constants and types for the CPU data-memory responder.
// MMIO register offsets, default error read value and decode regions.
package cpu_mem_pkg;

    localparam logic [3:0] OFF_EXIT  = 4'h0;
    localparam logic [3:0] OFF_CYCLE = 4'h4;
    localparam logic [3:0] OFF_RDCNT = 4'h8;
    localparam logic [3:0] OFF_WRCNT = 4'hC;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_MMIO,
        REG_UNMAPPED
    } region_e;

endpackage

// File: rtl/cpu_mem_mmio_regs.sv
// MMIO register block: exit/halt latch, free-running cycle counter and RAM access counters.
// Callers pre-qualify every strobe, so this block only needs to know about reset and halt.
module cpu_mem_mmio_regs
    import cpu_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        exit_we_i,
    input  logic [31:0] wdata_i,
    input  logic        rd_inc_i,
    input  logic        wr_inc_i,
    input  logic [3:0]  off_i,
    output logic [31:0] rdata_o,
    output logic        halt_o,
    output logic [31:0] halt_code_o
);

    logic        halt_q, halt_d;
    logic [31:0] halt_code_q, halt_code_d;
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        halt_d      = halt_q;
        halt_code_d = halt_code_q;
        // Only the first exit write is recorded; later ones leave the code intact.
        if (exit_we_i && !halt_q) begin
            halt_d      = 1'b1;
            halt_code_d = wdata_i;
        end
        cycle_d  = halt_q ? cycle_q : cycle_q + 32'd1;
        rd_cnt_d = rd_inc_i ? rd_cnt_q + 32'd1 : rd_cnt_q;
        wr_cnt_d = wr_inc_i ? wr_cnt_q + 32'd1 : wr_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            halt_q      <= 1'b0;
            halt_code_q <= 32'd0;
            cycle_q     <= 32'd0;
            rd_cnt_q    <= 32'd0;
            wr_cnt_q    <= 32'd0;
        end else begin
            halt_q      <= halt_d;
            halt_code_q <= halt_code_d;
            cycle_q     <= cycle_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
        end
    end

    always_comb begin
        unique case (off_i)
            OFF_CYCLE: rdata_o = cycle_q;
            OFF_RDCNT: rdata_o = rd_cnt_q;
            OFF_WRCNT: rdata_o = wr_cnt_q;
            default:   rdata_o = 32'd0;
        endcase
    end

    assign halt_o      = halt_q;
    assign halt_code_o = halt_code_q;

endmodule

// File: rtl/cpu_data_mem.sv
// Data-port responder for the single-cycle CPU: word RAM, MMIO window and error capture.
// Reads are combinational; writes, counters and error capture update on the rising edge.
module cpu_data_mem
    import cpu_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 16384,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
    parameter logic [31:0] ERR_DATA    = ERR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        halt,
    output logic [31:0] halt_code,
    output logic        err,
    output logic [31:0] err_addr
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

    logic [31:0] mem_q [DEPTH_WORDS];

    region_e     region;
    logic [AW-1:0] idx;
    logic        misaligned, bad_addr, legal_ram, err_evt;
    logic        ram_we, exit_we, rd_inc;
    logic [31:0] mmio_rdata;
    logic        err_q, err_d;
    logic [31:0] err_addr_q, err_addr_d;

    always_comb begin
        region = REG_UNMAPPED;
        if ({1'b0, data_addr} < RAM_BYTES) begin
            region = REG_RAM;
        end else if (data_addr[31:4] == MMIO_BASE[31:4]) begin
            region = REG_MMIO;
        end
    end

    assign idx        = data_addr[AW+1:2];
    assign misaligned = |data_addr[1:0];
    assign bad_addr   = misaligned || (region == REG_UNMAPPED);
    assign legal_ram  = !bad_addr && (region == REG_RAM) && !rst;

    assign ram_we  = data_write && legal_ram;
    // A simultaneous read+write is accounted as a write only.
    assign rd_inc  = data_read && !data_write && legal_ram;
    assign exit_we = data_write && !bad_addr && (region == REG_MMIO)
                     && (data_addr[3:0] == OFF_EXIT) && !rst;
    assign err_evt = !rst && (((data_read || data_write) && bad_addr)
                     || (data_read && data_write));

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem_q[idx] <= data_in;
        end
    end

    cpu_mem_mmio_regs u_regs (
        .clk         (clk),
        .rst         (rst),
        .exit_we_i   (exit_we),
        .wdata_i     (data_in),
        .rd_inc_i    (rd_inc),
        .wr_inc_i    (ram_we),
        .off_i       (data_addr[3:0]),
        .rdata_o     (mmio_rdata),
        .halt_o      (halt),
        .halt_code_o (halt_code)
    );

    always_comb begin
        data_out = 32'd0;
        if (data_read) begin
            if (bad_addr) begin
                data_out = ERR_DATA;
            end else if (region == REG_RAM) begin
                data_out = mem_q[idx];
            end else begin
                data_out = mmio_rdata;
            end
        end
    end

    always_comb begin
        err_d      = err_q;
        err_addr_d = err_addr_q;
        if (err_evt && !err_q) begin
            err_d      = 1'b1;
            err_addr_d = data_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q      <= 1'b0;
            err_addr_q <= 32'd0;
        end else begin
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign err      = err_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_cpu_data_mem.sv
// Directed bench for cpu_data_mem: RAM, MMIO, error capture, halt and reset behaviour.
module tb_cpu_data_mem;

    localparam logic [31:0] MMIO = 32'hFFFF_0000;
    localparam logic [31:0] BEEF = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        data_read = 1'b0;
    logic        data_write = 1'b0;
    logic [31:0] data_addr = 32'd0;
    logic [31:0] data_in = 32'd0;
    logic [31:0] data_out;
    logic        halt;
    logic [31:0] halt_code;
    logic        err;
    logic [31:0] err_addr;

    int          total = 0;
    int          bad = 0;
    logic [31:0] rd_val;
    logic [31:0] exp_cyc = 32'd0;
    bit          exp_halt = 1'b0;

    cpu_data_mem dut (
        .clk        (clk),
        .rst        (rst),
        .data_read  (data_read),
        .data_write (data_write),
        .data_addr  (data_addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .halt       (halt),
        .halt_code  (halt_code),
        .err        (err),
        .err_addr   (err_addr)
    );

    always #5 clk = ~clk;

    // Reference cycle counter: counts every non-reset edge until the bench records a halt.
    always @(posedge clk) begin
        if (rst) exp_cyc <= 32'd0;
        else if (!exp_halt) exp_cyc <= exp_cyc + 32'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive after the edge, capture data_out mid-cycle, release after the edge.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] din);
        data_read  = rd;
        data_write = wr;
        data_addr  = addr;
        data_in    = din;
        @(negedge clk);
        rd_val = data_out;
        @(posedge clk);
        #1;
        data_read  = 1'b0;
        data_write = 1'b0;
        data_addr  = 32'd0;
        data_in    = 32'd0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        access(1'b1, 1'b0, addr, 32'd0);
        chk(tag, rd_val, exp);
    endtask

    initial begin
        dut.mem_q[0] = 32'h0BAD_0000;
        dut.mem_q[3] = 32'h1234_5678;
        dut.mem_q[8] = 32'h0000_0001;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_halt", {31'd0, halt}, 32'd0);
        chk("rst_halt_code", halt_code, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);
        chk("idle_data_out", data_out, 32'd0);
        rst = 1'b0;

        repeat (10) @(posedge clk);
        #1;
        rd_chk("cycle10", MMIO + 32'h4, 32'd10);

        rd_chk("ram3", 32'h0C, 32'h1234_5678);
        rd_chk("rdcnt1", MMIO + 32'h8, 32'd1);

        access(1'b0, 1'b1, 32'h10, 32'hCAFE_F00D);
        rd_chk("ram4", 32'h10, 32'hCAFE_F00D);
        rd_chk("wrcnt1", MMIO + 32'hC, 32'd1);
        rd_chk("rdcnt2", MMIO + 32'h8, 32'd2);

        access(1'b1, 1'b0, 32'h12, 32'd0);
        chk("misalign_rd", rd_val, BEEF);
        chk("err_set", {31'd0, err}, 32'd1);
        chk("err_addr", err_addr, 32'h12);
        access(1'b0, 1'b1, 32'h0004_0000, 32'h5555_5555);
        chk("err_addr_kept", err_addr, 32'h12);
        access(1'b0, 1'b1, 32'h11, 32'h6666_6666);
        rd_chk("ram0_kept", 32'h0, 32'h0BAD_0000);
        rd_chk("ram4_kept", 32'h10, 32'hCAFE_F00D);
        rd_chk("unmapped_rd", 32'h8000_0000, BEEF);
        rd_chk("exit_rd0", MMIO, 32'd0);
        rd_chk("wrcnt_kept", MMIO + 32'hC, 32'd1);
        rd_chk("rdcnt4", MMIO + 32'h8, 32'd4);

        access(1'b0, 1'b1, MMIO + 32'h4, 32'd123);
        rd_chk("cycle_ro", MMIO + 32'h4, exp_cyc);

        access(1'b0, 1'b1, MMIO, 32'd7);
        exp_halt = 1'b1;
        chk("halt_set", {31'd0, halt}, 32'd1);
        chk("halt_code7", halt_code, 32'd7);
        access(1'b0, 1'b1, MMIO, 32'd9);
        chk("halt_code_kept", halt_code, 32'd7);
        rd_chk("cycle_frozen", MMIO + 32'h4, exp_cyc);
        repeat (3) @(posedge clk);
        #1;
        rd_chk("cycle_frozen2", MMIO + 32'h4, exp_cyc);
        rd_chk("ram_after_halt", 32'h10, 32'hCAFE_F00D);

        exp_halt = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rearm_halt", {31'd0, halt}, 32'd0);
        chk("rearm_code", halt_code, 32'd0);
        chk("rearm_err", {31'd0, err}, 32'd0);
        chk("rearm_err_addr", err_addr, 32'd0);
        rd_chk("cycle_restart", MMIO + 32'h4, 32'd0);

        access(1'b1, 1'b1, 32'h20, 32'h2);
        chk("proto_rd_old", rd_val, 32'h1);
        chk("proto_err", {31'd0, err}, 32'd1);
        chk("proto_err_addr", err_addr, 32'h20);
        rd_chk("proto_rdcnt", MMIO + 32'h8, 32'd0);
        rd_chk("proto_wrcnt", MMIO + 32'hC, 32'd1);
        rd_chk("ram8_new", 32'h20, 32'h2);

        // A write presented during reset must be dropped.
        rst        = 1'b1;
        data_write = 1'b1;
        data_addr  = 32'h20;
        data_in    = 32'h3;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        data_write = 1'b0;
        data_addr  = 32'd0;
        data_in    = 32'd0;
        chk("rst2_err", {31'd0, err}, 32'd0);
        rd_chk("rst2_wrcnt", MMIO + 32'hC, 32'd0);
        rd_chk("ram8_kept", 32'h20, 32'h2);
        rd_chk("rst2_rdcnt", MMIO + 32'h8, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_data_mem.md
Name: cpu_data_mem

Overview:
Data-memory responder on the far end of the single-cycle CPU's data port (data_read/data_write/data_addr/data_in/data_out). It holds a word-addressed RAM plus a small MMIO window: halt/exit register, free-running cycle counter, and read/write access counters. It reports protocol and address errors to the bench. The CPU is the sole initiator; this block never stalls it.

Parameters:
DEPTH_WORDS, 16384, RAM size in 32-bit words (64 KiB); must be a power of two.
MMIO_BASE, 32'hFFFF_0000, byte base address of the 16-byte MMIO window.
ERR_DATA, 32'hDEAD_BEEF, value returned on an erroneous read.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
data_read  in  1  read request, held by the CPU for one full cycle
data_write  in  1  write request, held for one full cycle
data_addr  in  32  byte address; word accesses only
data_in  in  32  write data
data_out  out  32  read data
halt  out  1  sticky; program wrote the exit register
halt_code  out  32  value written to the exit register
err  out  1  sticky; first access or protocol error seen
err_addr  out  32  data_addr of the first error

Behaviour:
- Address decode:
  - RAM when data_addr < DEPTH_WORDS*4; word index is data_addr[log2(DEPTH_WORDS)+1:2].
  - MMIO when data_addr[31:4] == MMIO_BASE[31:4].
  - Anything else is unmapped.
- MMIO map, byte offsets:
  - 0x0 EXIT: write-only; reads return 0.
  - 0x4 CYCLE: read-only.
  - 0x8 RDCNT: read-only.
  - 0xC WRCNT: read-only.
  - Writes to read-only registers are ignored and are not errors.
- Read timing:
  - data_out is combinational from data_addr while data_read=1.
  - The CPU samples data_out at the next rising edge, so effective latency is 1 edge.
  - data_out = 0 when data_read=0.
- Writes commit at the rising edge where data_write=1. A read of the same word in the same cycle returns pre-write content.
- Alignment: data_addr[1:0] != 0 is an error.
  - Read: data_out = ERR_DATA.
  - Write: discarded; RAM is unchanged.
- Unmapped access is an error. Reads return ERR_DATA; writes are discarded.
- Protocol error: data_read and data_write both 1 in the same cycle.
  - Write is performed if otherwise legal.
  - data_out shows pre-write data.
  - err is set.
- Error capture:
  - On the first error edge: err <= 1, err_addr <= data_addr.
  - Later errors do not update err_addr.
  - Only rst clears err and err_addr.
- EXIT write:
  - If halt=0: halt <= 1, halt_code <= data_in.
  - If halt=1: ignored and halt_code is kept; not an error.
  - RAM remains accessible after halt.
- CYCLE:
  - Increments by 1 every non-reset edge while halt=0; frozen once halt=1.
  - Wraps 32'hFFFF_FFFF -> 0.
  - A CYCLE read returns the pre-increment value.
- RDCNT / WRCNT:
  - Increment on every legal RAM read / write edge; MMIO, erroneous and discarded accesses do not count.
  - Both wrap at 32 bits.
  - In a simultaneous read+write cycle, only WRCNT increments.
- Reset:
  - Clears halt, halt_code, err, err_addr, CYCLE, RDCNT, WRCNT to 0.
  - RAM contents are NOT cleared, so the bench may preload via hierarchical access before or during rst.
  - rst has priority: any access in a reset cycle is ignored (no write, no count, no error). data_out still follows the combinational read rule.
- Reset mid-run, including after halt: counters restart from 0 at the first non-reset edge; halt and err are re-armed.

Decomposition:
- Package cpu_mem_pkg:
  - MMIO offset constants: EXIT=4'h0, CYCLE=4'h4, RDCNT=4'h8, WRCNT=4'hC.
  - Default ERR_DATA.
  - Decode-region enum: {REG_RAM, REG_MMIO, REG_UNMAPPED}.
- One sub-module, cpu_mem_mmio_regs: owns EXIT/halt, CYCLE, RDCNT, WRCNT and their read mux.
- The top level keeps the RAM array, decode and error capture.

Test Plan:
- Preload RAM[3]=32'h1234_5678; read addr 0x0C -> data_out=32'h1234_5678 during the read cycle; RDCNT=1 afterwards.
- Write 0xCAFE_F00D to 0x10, then read 0x10 -> 0xCAFE_F00D; WRCNT=1.
- Read 0x12 (misaligned) -> data_out=0xDEAD_BEEF, err=1, err_addr=0x12. Then write 0x4_0000 (unmapped) -> err_addr stays 0x12 and RAM is unchanged.
- Run 10 idle cycles after reset, then read MMIO_BASE+4 -> 32'd10.
- Write 32'd7 to MMIO_BASE+0 -> halt=1, halt_code=7. Write 32'd9 to EXIT -> halt_code stays 7; CYCLE frozen.
- Assert data_read and data_write to 0x20 (old value 0x1, new value 0x2) together -> data_out=0x1, RAM[8]=0x2, err=1, WRCNT+1, RDCNT unchanged. Then pulse rst -> err=0, counters=0, RAM[8] still 0x2.
